// File: rtl/add_pipe_pkg.sv
// add_pipe_pkg: shared types and elaboration helpers for the pipelined
// adder/subtractor (add_nbit_pipe and its add_pipe_seg segments).
package add_pipe_pkg;

  // Operation mode carried by the sub input.
  typedef enum logic {
    ADD_MODE_ADD = 1'b0,
    ADD_MODE_SUB = 1'b1
  } add_mode_e;

  // Width of one carry-chain segment.
  function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

  // Legal configuration: 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES.
  function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
    return (width >= 1) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_nbit_pipe_if.sv
// add_nbit_pipe_if: operand/result handshake bundle for add_nbit_pipe.
//   master: operand source and result sink (drives in_valid/a/b/cin/sub/out_ready)
//   slave : the adder pipeline (drives in_ready/out_valid/sum/cout/ovf)
interface add_nbit_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_pipe_seg.sv
// add_pipe_seg: one pipeline stage of add_nbit_pipe. Adds slice IDX of the
// (already mode-conditioned) operands using the carry from the previous stage,
// merges the slice into the partial result and registers everything when adv_i.
//   clk, rst_n        : clock, synchronous active-low reset
//   adv_i             : global pipeline advance
//   valid_i/valid_o   : slot valid
//   carry_i/carry_o   : carry into / out of this segment
//   ovf_i/ovf_o       : signed overflow (computed by the last segment only)
//   a_i,b_i/a_o,b_o   : skewed operands (upper slices still to be added)
//   sum_i/sum_o       : partial result (lower slices already added)
module add_pipe_seg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEG_W = 4,
  parameter int unsigned IDX   = 0,
  parameter bit          LAST  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic             ovf_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] sum_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] sum_o
);
  localparam int unsigned LO = IDX * SEG_W;
  localparam int unsigned HI = LO + SEG_W - 1;

  logic [SEG_W:0]   seg_c;
  logic             msb_cin_c;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  logic             valid_q;
  logic             carry_q;
  logic             ovf_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;

  // Slice adder; carry into the slice MSB recovered as a ^ b ^ s at that bit.
  always_comb begin
    seg_c             = {1'b0, a_i[LO +: SEG_W]} + {1'b0, b_i[LO +: SEG_W]} + (SEG_W+1)'(carry_i);
    msb_cin_c         = a_i[HI] ^ b_i[HI] ^ seg_c[SEG_W-1];
    sum_d             = sum_i;
    sum_d[LO +: SEG_W] = seg_c[SEG_W-1:0];
    ovf_d             = LAST ? (msb_cin_c ^ seg_c[SEG_W]) : ovf_i;
  end

  // Stage register: clears on reset, holds when the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      carry_q <= seg_c[SEG_W];
      ovf_q   <= ovf_d;
      a_q     <= a_i;
      b_q     <= b_i;
      sum_q   <= sum_d;
    end
  end

  assign valid_o = valid_q;
  assign carry_o = carry_q;
  assign ovf_o   = ovf_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;

endmodule

// File: rtl/add_nbit_pipe.sv
// add_nbit_pipe: pipelined WIDTH-bit adder/subtractor with carry-in, carry-out
// and signed overflow, split into STAGES carry-chain segments.
//   clock0        : clock, rising edge
//   global_resetn : synchronous active-low reset
//   bus (slave)   : in_valid/in_ready/a/b/cin/sub operand side,
//                   out_valid/out_ready/sum/cout/ovf result side
module add_nbit_pipe
  import add_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic           clock0,
  input logic           global_resetn,
  add_nbit_pipe_if.slave bus
);
  localparam int unsigned SEG_W = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("add_nbit_pipe: need 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
  end

  // Index 0 is the conditioned input; index k+1 is the output of segment k.
  logic             valid_s [STAGES+1];
  logic             carry_s [STAGES+1];
  logic             ovf_s   [STAGES+1];
  logic [WIDTH-1:0] a_s     [STAGES+1];
  logic [WIDTH-1:0] b_s     [STAGES+1];
  logic [WIDTH-1:0] sum_s   [STAGES+1];

  add_mode_e mode_c;
  logic      adv_c;
  logic      unused_tail;

  // Whole pipeline moves together unless the final result is blocked.
  assign adv_c        = !valid_s[STAGES] || bus.out_ready;
  assign bus.in_ready = adv_c;

  // Subtraction is a + ~b + ~cin; invert once at entry so the mode travels
  // with the beat inside the operand and carry registers.
  assign mode_c     = add_mode_e'(bus.sub);
  assign valid_s[0] = bus.in_valid;
  assign a_s[0]     = bus.a;
  assign b_s[0]     = (mode_c == ADD_MODE_SUB) ? ~bus.b : bus.b;
  assign carry_s[0] = (mode_c == ADD_MODE_SUB) ? ~bus.cin : bus.cin;
  assign ovf_s[0]   = 1'b0;
  assign sum_s[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    add_pipe_seg #(
      .WIDTH (WIDTH),
      .SEG_W (SEG_W),
      .IDX   (k),
      .LAST  (k == STAGES - 1)
    ) u_seg (
      .clk     (clock0),
      .rst_n   (global_resetn),
      .adv_i   (adv_c),
      .valid_i (valid_s[k]),
      .carry_i (carry_s[k]),
      .ovf_i   (ovf_s[k]),
      .a_i     (a_s[k]),
      .b_i     (b_s[k]),
      .sum_i   (sum_s[k]),
      .valid_o (valid_s[k+1]),
      .carry_o (carry_s[k+1]),
      .ovf_o   (ovf_s[k+1]),
      .a_o     (a_s[k+1]),
      .b_o     (b_s[k+1]),
      .sum_o   (sum_s[k+1])
    );
  end

  // Operands are fully consumed by the last segment.
  assign unused_tail = ^{a_s[STAGES], b_s[STAGES]};

  assign bus.out_valid = valid_s[STAGES];
  assign bus.sum       = sum_s[STAGES];
  assign bus.cout      = carry_s[STAGES];
  assign bus.ovf       = ovf_s[STAGES];

endmodule

// File: tb/tb_add_nbit_pipe.sv
// tb_add_nbit_pipe: directed self-checking bench for add_nbit_pipe across
// four configurations (1/1, 8/2, 8/4, 16/4).
module tb_add_nbit_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_nbit_pipe_if #(.WIDTH(1))  if1 ();
  add_nbit_pipe_if #(.WIDTH(8))  if2 ();
  add_nbit_pipe_if #(.WIDTH(8))  if3 ();
  add_nbit_pipe_if #(.WIDTH(16)) if4 ();

  add_nbit_pipe #(.WIDTH(1),  .STAGES(1)) u1 (.clock0(clk), .global_resetn(rst_n), .bus(if1));
  add_nbit_pipe #(.WIDTH(8),  .STAGES(2)) u2 (.clock0(clk), .global_resetn(rst_n), .bus(if2));
  add_nbit_pipe #(.WIDTH(8),  .STAGES(4)) u3 (.clock0(clk), .global_resetn(rst_n), .bus(if3));
  add_nbit_pipe #(.WIDTH(16), .STAGES(4)) u4 (.clock0(clk), .global_resetn(rst_n), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    case (d)
      1: begin if1.in_valid = v; if1.a = a[0];    if1.b = b[0];    if1.cin = cin; if1.sub = sub; end
      2: begin if2.in_valid = v; if2.a = a[7:0];  if2.b = b[7:0];  if2.cin = cin; if2.sub = sub; end
      3: begin if3.in_valid = v; if3.a = a[7:0];  if3.b = b[7:0];  if3.cin = cin; if3.sub = sub; end
      default: begin if4.in_valid = v; if4.a = a; if4.b = b;       if4.cin = cin; if4.sub = sub; end
    endcase
  endtask

  // {in_ready, out_valid, cout, ovf, sum zero-extended to 16}
  function automatic logic [19:0] obs(input int d);
    case (d)
      1: return {if1.in_ready, if1.out_valid, if1.cout, if1.ovf, 15'd0, if1.sum};
      2: return {if2.in_ready, if2.out_valid, if2.cout, if2.ovf, 8'd0, if2.sum};
      3: return {if3.in_ready, if3.out_valid, if3.cout, if3.ovf, 8'd0, if3.sum};
      default: return {if4.in_ready, if4.out_valid, if4.cout, if4.ovf, if4.sum};
    endcase
  endfunction

  // Independent 16-bit reference: {cout, ovf, sum}; ovf from operand/result signs.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
    logic [16:0] r;
    logic        v;
    if (sub) begin
      r = {1'b0, a} + {1'b0, ~b} + {16'd0, ~cin};
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end
    return {r[16], v, r[15:0]};
  endfunction

  function automatic logic [15:0] opa(input int i);
    return 16'(i * 4951 + 2575);
  endfunction

  function automatic logic [15:0] opb(input int i);
    return 16'((i * 9320) ^ 61453);
  endfunction

  // One beat with out_ready held high: check acceptance, latency and result.
  task automatic beat(input int d, input int lat, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic sub, input logic [17:0] exp, input string tag);
    logic [19:0] o;
    @(negedge clk);
    drive(d, 1'b1, a, b, cin, sub);
    #1 o = obs(d);
    chk({tag, " in_ready"}, 32'(o[19]), 32'd1);
    @(posedge clk);
    #1 drive(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i < lat; i++) begin
      o = obs(d);
      chk($sformatf("%s early_valid%0d", tag, i), 32'(o[18]), 32'd0);
      @(posedge clk);
      #1;
    end
    o = obs(d);
    chk({tag, " out_valid"}, 32'(o[18]), 32'd1);
    chk({tag, " result"}, 32'(o[17:0]), 32'(exp));
  endtask

  initial begin
    logic [19:0] o;
    logic [17:0] exp_q [32];
    int          sent;
    int          rcvd;
    int          stalls;

    rst_n = 1'b0;
    for (int d = 1; d <= 4; d++) drive(d, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    if3.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 1; d <= 4; d++) chk($sformatf("reset_state_dut%0d", d), 32'(obs(d)), 32'h80000);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1, STAGES=1 truth table
    beat(1, 1, 16'd0, 16'd0, 1'b0, 1'b0, 18'h00000, "w1_00");
    beat(1, 1, 16'd0, 16'd1, 1'b0, 1'b0, 18'h00001, "w1_01");
    beat(1, 1, 16'd1, 16'd0, 1'b0, 1'b0, 18'h00001, "w1_10");
    beat(1, 1, 16'd1, 16'd1, 1'b0, 1'b0, 18'h30000, "w1_11");
    beat(1, 1, 16'd0, 16'd1, 1'b0, 1'b0, 18'h00001, "w1_01b");
    beat(1, 1, 16'd1, 16'd0, 1'b0, 1'b0, 18'h00001, "w1_10b");
    beat(1, 1, 16'd1, 16'd1, 1'b0, 1'b0, 18'h30000, "w1_11b");

    // WIDTH=8, STAGES=2 add
    beat(2, 2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 18'h20000, "w8s2_ff_01");
    beat(2, 2, 16'h007F, 16'h0001, 1'b0, 1'b0, 18'h10080, "w8s2_7f_01");
    beat(2, 2, 16'h0080, 16'h0080, 1'b0, 1'b0, 18'h30000, "w8s2_80_80");
    beat(2, 2, 16'h0012, 16'h0034, 1'b1, 1'b0, 18'h00047, "w8s2_cin");

    // WIDTH=8, STAGES=4 subtract
    beat(3, 4, 16'h0005, 16'h0007, 1'b0, 1'b1, 18'h000FE, "w8s4_05_07");
    beat(3, 4, 16'h0080, 16'h0001, 1'b0, 1'b1, 18'h3007F, "w8s4_80_01");
    beat(3, 4, 16'h0010, 16'h000F, 1'b1, 1'b1, 18'h20000, "w8s4_10_0f_b");

    // WIDTH=16, STAGES=4 streaming, alternating mode, 5-cycle stall mid-stream
    for (int i = 0; i < 32; i++) exp_q[i] = model16(opa(i), opb(i), i[1], i[0]);
    sent   = 0;
    rcvd   = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 32; cyc++) begin
      @(negedge clk);
      if4.out_ready = !(cyc >= 10 && cyc < 15);
      if (sent < 32) drive(4, 1'b1, opa(sent), opb(sent), sent[1], sent[0]);
      else           drive(4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
      #1 o = obs(4);
      if (o[18] && !if4.out_ready) begin
        stalls++;
        chk($sformatf("stall_in_ready c%0d", cyc), 32'(o[19]), 32'd0);
        chk($sformatf("stall_hold c%0d", cyc), 32'(o[17:0]), 32'(exp_q[rcvd]));
      end
      if (o[18] && if4.out_ready) begin
        chk($sformatf("stream_beat%0d", rcvd), 32'(o[17:0]), 32'(exp_q[rcvd]));
        rcvd++;
      end
      if (if4.in_valid && o[19]) sent++;
    end
    chk("stream_received", 32'(rcvd), 32'd32);
    chk("stream_sent", 32'(sent), 32'd32);
    chk("stream_stall_cycles", 32'(stalls), 32'd5);
    if4.out_ready = 1'b1;
    @(negedge clk);
    drive(4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    #1 chk("stream_no_extra", 32'(obs(4) & 20'h40000), 32'd0);

    // Reset with three beats in flight: all dropped, next beat normal latency
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(4, 1'b1, 16'(16'h1111 * (k + 1)), 16'h0101, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(4, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_mid_state", 32'(obs(4)), 32'h80000);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 chk($sformatf("rst_drop%0d", i), 32'(obs(4) & 20'h40000), 32'd0);
    end
    beat(4, 4, 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555, "post_rst");
    beat(4, 4, 16'h8000, 16'h0001, 1'b0, 1'b1, model16(16'h8000, 16'h0001, 1'b0, 1'b1), "post_rst_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
